// File: rtl/ydriver_scan_ctrl_if.sv
// Pin bundle between the LCD timing source and the Y-driver row-scan controller.
interface ydriver_scan_ctrl_if #(
   parameter int PHASES = 4,
   parameter int RW     = 8
);
   // There is no valid/ready handshake on this bundle. cpl_in, s_in and fr_in are
   // free-running pins, asynchronous to clk. A line event is the rising edge of cpl_in.
   // s_in and fr_in are qualified by that edge. Every output is a registered level.
   // The exceptions are frame_done and restart, which are one-clk pulses.
   logic              cpl_in;
   logic              s_in;
   logic              fr_in;
   logic [PHASES-1:0] ck;
   logic              s_int;
   logic              fr_int;
   logic              n_fr_int;
   logic [RW-1:0]     row;
   logic              scanning;
   logic              frame_done;
   logic              restart;

   modport master (
      output cpl_in, s_in, fr_in,
      input  ck, s_int, fr_int, n_fr_int, row, scanning, frame_done, restart
   );

   modport slave (
      input  cpl_in, s_in, fr_in,
      output ck, s_int, fr_int, n_fr_int, row, scanning, frame_done, restart
   );
endinterface

// File: rtl/ydriver_scan_ctrl.sv
// Row-scan controller for the LCD Y (common) driver. It produces a rotating one-hot
// shift clock, the row index, frame status and a drive polarity with a selectable source.
module ydriver_scan_ctrl #(
   parameter int ROWS     = 144,
   parameter int PHASES   = 4,
   parameter int FR_MODE  = 0,
   parameter int FR_LINES = 1,
   localparam int RW      = ($clog2(ROWS) > 1) ? $clog2(ROWS) : 1
) (
   input logic              clk,
   input logic              n_rst,
   ydriver_scan_ctrl_if.slave pins
);

   localparam int LW = ($clog2(FR_LINES) > 1) ? $clog2(FR_LINES) : 1;
   localparam logic [RW-1:0]     LAST_ROW  = RW'(ROWS - 1);
   localparam logic [LW-1:0]     LCNT_LAST = LW'(FR_LINES - 1);
   localparam logic [PHASES-1:0] CK_FIRST  = PHASES'(1);

   // The state is visible on the scanning output.
   typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_e;

   logic [1:0]        cpl_sync_q, s_sync_q, fr_sync_q;
   logic              cpl_prev_q;
   logic [1:0]        prime_q;
   logic              armed_q;
   state_e            state_q, state_d;
   logic [RW-1:0]     row_q, row_d;
   logic [PHASES-1:0] ck_q, ck_d;
   logic              s_int_q, s_int_d;
   logic              fr_q, fr_d;
   logic              frame_done_q, frame_done_d;
   logic              restart_q, restart_d;
   logic [LW-1:0]     lcnt_q, lcnt_d;

   logic cpl_s, s_s, fr_s, lstb, last_row;

   assign cpl_s    = cpl_sync_q[1];
   assign s_s      = s_sync_q[1];
   assign fr_s     = fr_sync_q[1];
   assign last_row = (row_q == LAST_ROW);

   // prime_q[1] marks that cpl_sync_q[1] holds a real pin sample rather than its reset value.
   // armed_q is then set only when CPL is genuinely seen low. As a result, CPL held high
   // through reset release cannot produce a strobe.
   assign lstb = armed_q & cpl_s & ~cpl_prev_q;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cpl_sync_q   <= '0;
         s_sync_q     <= '0;
         fr_sync_q    <= '0;
         cpl_prev_q   <= 1'b0;
         prime_q      <= '0;
         armed_q      <= 1'b0;
         state_q      <= IDLE;
         row_q        <= '0;
         ck_q         <= '0;
         s_int_q      <= 1'b0;
         fr_q         <= 1'b0;
         frame_done_q <= 1'b0;
         restart_q    <= 1'b0;
         lcnt_q       <= '0;
      end else begin
         cpl_sync_q   <= {cpl_sync_q[0], pins.cpl_in};
         s_sync_q     <= {s_sync_q[0], pins.s_in};
         fr_sync_q    <= {fr_sync_q[0], pins.fr_in};
         cpl_prev_q   <= cpl_s;
         prime_q      <= {prime_q[0], 1'b1};
         armed_q      <= armed_q | (prime_q[1] & ~cpl_s);
         state_q      <= state_d;
         row_q        <= row_d;
         ck_q         <= ck_d;
         s_int_q      <= s_int_d;
         fr_q         <= fr_d;
         frame_done_q <= frame_done_d;
         restart_q    <= restart_d;
         lcnt_q       <= lcnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (lstb) begin
         case (state_q)
            IDLE:    if (s_s) state_d = SCAN;
            SCAN:    if (!s_s && last_row) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // S outranks end of frame, so an S on the last row restarts the frame instead of ending it.
   always_comb begin
      row_d        = row_q;
      ck_d         = ck_q;
      s_int_d      = s_int_q;
      fr_d         = fr_q;
      lcnt_d       = lcnt_q;
      frame_done_d = 1'b0;
      restart_d    = 1'b0;
      if (lstb) begin
         s_int_d = s_s;
         if (s_s) begin
            row_d     = '0;
            ck_d      = CK_FIRST;
            restart_d = (state_q == SCAN);
         end else if (state_q == IDLE) begin
            ck_d = '0;
         end else if (last_row) begin
            row_d        = '0;
            ck_d         = '0;
            frame_done_d = 1'b1;
         end else begin
            row_d = row_q + RW'(1);
            ck_d  = {ck_q[PHASES-2:0], ck_q[PHASES-1]};
         end

         // In mode 2 the line counter restarts with each frame, but the polarity does not.
         // This keeps the DC balance running across frame boundaries.
         if (FR_MODE == 0) begin
            fr_d = fr_s;
         end else if (FR_MODE == 1) begin
            if (s_s) fr_d = ~fr_q;
         end else begin
            if (s_s) begin
               lcnt_d = '0;
            end else if (state_q == SCAN) begin
               if (lcnt_q == LCNT_LAST) begin
                  lcnt_d = '0;
                  fr_d   = ~fr_q;
               end else begin
                  lcnt_d = lcnt_q + LW'(1);
               end
            end
         end
      end
   end

   assign pins.ck         = ck_q;
   assign pins.row        = row_q;
   assign pins.scanning   = (state_q == SCAN);
   assign pins.s_int      = s_int_q;
   assign pins.fr_int     = fr_q;
   assign pins.n_fr_int   = ~fr_q;
   assign pins.frame_done = frame_done_q;
   assign pins.restart    = restart_q;

endmodule

// File: tb/tb_ydriver_scan_ctrl.sv
// Bench for ydriver_scan_ctrl. It drives three configurations from one set of pins:
// A (4 rows, external FR), B (6 rows, per-frame FR) and C (4 rows, FR every 2 lines).
module tb_ydriver_scan_ctrl;

   localparam int EW = 13;
   localparam logic [EW-1:0] RST_VEC = 13'h0001;

   logic clk;
   logic n_rst;
   logic cpl, s_pin, fr_pin;

   int errors = 0;
   int checks = 0;

   logic [3*EW-1:0] exp_q[$];

   ydriver_scan_ctrl_if #(.PHASES(4), .RW(2)) ifa ();
   ydriver_scan_ctrl_if #(.PHASES(4), .RW(3)) ifb ();
   ydriver_scan_ctrl_if #(.PHASES(4), .RW(2)) ifc ();

   assign ifa.cpl_in = cpl;  assign ifa.s_in = s_pin;  assign ifa.fr_in = fr_pin;
   assign ifb.cpl_in = cpl;  assign ifb.s_in = s_pin;  assign ifb.fr_in = fr_pin;
   assign ifc.cpl_in = cpl;  assign ifc.s_in = s_pin;  assign ifc.fr_in = fr_pin;

   ydriver_scan_ctrl #(.ROWS(4), .PHASES(4), .FR_MODE(0), .FR_LINES(1)) dut_a (
      .clk(clk), .n_rst(n_rst), .pins(ifa));
   ydriver_scan_ctrl #(.ROWS(6), .PHASES(4), .FR_MODE(1), .FR_LINES(1)) dut_b (
      .clk(clk), .n_rst(n_rst), .pins(ifb));
   ydriver_scan_ctrl #(.ROWS(4), .PHASES(4), .FR_MODE(2), .FR_LINES(2)) dut_c (
      .clk(clk), .n_rst(n_rst), .pins(ifc));

   // Observed vector: row[12:10] ck[9:6] scanning[5] frame_done[4] restart[3] s_int[2] fr[1] n_fr[0]
   logic [EW-1:0] obs [3];
   assign obs[0] = {1'b0, ifa.row, ifa.ck, ifa.scanning, ifa.frame_done, ifa.restart,
                    ifa.s_int, ifa.fr_int, ifa.n_fr_int};
   assign obs[1] = {ifb.row, ifb.ck, ifb.scanning, ifb.frame_done, ifb.restart,
                    ifb.s_int, ifb.fr_int, ifb.n_fr_int};
   assign obs[2] = {1'b0, ifc.row, ifc.ck, ifc.scanning, ifc.frame_done, ifc.restart,
                    ifc.s_int, ifc.fr_int, ifc.n_fr_int};

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, got no finish, expected finish");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog");
   end

   // reference model, one slot per configuration
   int   rows_t [3] = '{4, 6, 4};
   int   mode_t [3] = '{0, 1, 2};
   int   frl_t  [3] = '{1, 1, 2};
   int   m_row  [3];
   int   m_lc   [3];
   logic [3:0] m_ck [3];
   logic m_scan [3];
   logic m_fd   [3];
   logic m_rs   [3];
   logic m_sint [3];
   logic m_fr   [3];

   function automatic void model_reset();
      for (int d = 0; d < 3; d++) begin
         m_row[d] = 0; m_lc[d] = 0; m_ck[d] = 4'b0000; m_scan[d] = 1'b0;
         m_fd[d] = 1'b0; m_rs[d] = 1'b0; m_sint[d] = 1'b0; m_fr[d] = 1'b0;
      end
   endfunction

   function automatic void model_apply(input logic s, input logic f);
      for (int d = 0; d < 3; d++) begin
         m_fd[d] = 1'b0;
         m_rs[d] = 1'b0;
         if (mode_t[d] == 0) begin
            m_fr[d] = f;
         end else if (mode_t[d] == 1) begin
            if (s) m_fr[d] = ~m_fr[d];
         end else begin
            if (s) m_lc[d] = 0;
            else if (m_scan[d]) begin
               if (m_lc[d] == frl_t[d] - 1) begin m_lc[d] = 0; m_fr[d] = ~m_fr[d]; end
               else m_lc[d]++;
            end
         end
         m_sint[d] = s;
         if (!m_scan[d]) begin
            if (s) begin m_scan[d] = 1'b1; m_row[d] = 0; m_ck[d] = 4'b0001; end
            else m_ck[d] = 4'b0000;
         end else if (s) begin
            m_row[d] = 0; m_ck[d] = 4'b0001; m_rs[d] = 1'b1;
         end else if (m_row[d] == rows_t[d] - 1) begin
            m_scan[d] = 1'b0; m_row[d] = 0; m_ck[d] = 4'b0000; m_fd[d] = 1'b1;
         end else begin
            m_row[d]++;
            m_ck[d] = {m_ck[d][2:0], m_ck[d][3]};
         end
      end
   endfunction

   function automatic logic [EW-1:0] model_vec(input int d);
      return {3'(m_row[d]), m_ck[d], m_scan[d], m_fd[d], m_rs[d], m_sint[d], m_fr[d], ~m_fr[d]};
   endfunction

   // driver: one line strobe with S/FR set up a cycle ahead of the CPL edge
   task automatic strobe(input logic s, input logic f);
      logic [EW-1:0]   pre [3];
      logic [3*EW-1:0] e;
      for (int d = 0; d < 3; d++) begin
         pre[d] = model_vec(d);
         pre[d][4:3] = 2'b00;
      end
      model_apply(s, f);
      exp_q.push_back({model_vec(2), model_vec(1), model_vec(0)});
      @(negedge clk); s_pin = s; fr_pin = f;
      @(negedge clk); cpl = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (obs[d] !== pre[d]) begin
            errors++;
            $display("FAIL latency dut%0d: got %b, expected %b (unchanged)", d, obs[d], pre[d]);
         end
      end
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (obs[d] !== e[d*EW +: EW]) begin
            errors++;
            $display("FAIL strobe dut%0d: got %b, expected %b", d, obs[d], e[d*EW +: EW]);
         end
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (obs[d][4:3] !== 2'b00) begin
            errors++;
            $display("FAIL pulse_width dut%0d: frame_done/restart got %b, expected 00", d, obs[d][4:3]);
         end
      end
      @(negedge clk); cpl = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic reset_dut();
      n_rst = 1'b0; cpl = 1'b0; s_pin = 1'b0; fr_pin = 1'b0;
      model_reset();
      exp_q.delete();
      repeat (3) @(posedge clk);
      @(negedge clk); n_rst = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      n_rst = 1'b0; cpl = 1'b0; s_pin = 1'b0; fr_pin = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (obs[d] !== RST_VEC) begin
            errors++;
            $display("FAIL reset_values dut%0d: got %b, expected %b", d, obs[d], RST_VEC);
         end
      end
      @(negedge clk); n_rst = 1'b1;
      repeat (5) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (obs[d] !== RST_VEC) begin
            errors++;
            $display("FAIL idle_after_release dut%0d: got %b, expected %b", d, obs[d], RST_VEC);
         end
      end
   endtask

   task automatic test_polarity();
      logic exp_b, exp_c;
      for (int fr = 0; fr < 3; fr++) begin
         for (int i = 0; i < 7; i++) begin
            strobe(i == 0, 1'($urandom_range(0, 1)));
            if (i == 0) begin
               exp_b = (fr != 1);
               checks++;
               if (ifb.fr_int !== exp_b || ifb.n_fr_int !== ~exp_b) begin
                  errors++;
                  $display("FAIL fr_mode1 frame%0d: got fr=%b nfr=%b, expected fr=%b", fr, ifb.fr_int, ifb.n_fr_int, exp_b);
               end
            end
            if (fr == 0 && i < 5) begin
               exp_c = (i == 2 || i == 3);
               checks++;
               if (ifc.fr_int !== exp_c || ifc.n_fr_int !== ~exp_c) begin
                  errors++;
                  $display("FAIL fr_mode2 strobe%0d: got fr=%b nfr=%b, expected fr=%b", i + 1, ifc.fr_int, ifc.n_fr_int, exp_c);
               end
            end
         end
      end
   endtask

   task automatic test_basic_frame();
      for (int i = 0; i < 4; i++) begin
         strobe(i == 0, 1'($urandom_range(0, 1)));
         checks++;
         if (ifa.row !== 2'(i) || ifa.ck !== 4'(1 << i) || ifa.scanning !== 1'b1) begin
            errors++;
            $display("FAIL basic_row%0d: got row=%0d ck=%b scan=%b, expected row=%0d ck=%b scan=1", i, ifa.row, ifa.ck, ifa.scanning, i, 4'(1 << i));
         end
      end
      strobe(1'b0, 1'b0);
      checks++;
      if (ifa.scanning !== 1'b0 || ifa.ck !== 4'b0000 || ifa.row !== 2'd0) begin
         errors++;
         $display("FAIL basic_end: got scan=%b ck=%b row=%0d, expected scan=0 ck=0000 row=0", ifa.scanning, ifa.ck, ifa.row);
      end
   endtask

   task automatic test_phase_wrap();
      checks++;
      if (ifb.row !== 3'd4 || ifb.ck !== 4'b0001) begin
         errors++;
         $display("FAIL wrap_row4: got row=%0d ck=%b, expected row=4 ck=0001", ifb.row, ifb.ck);
      end
      strobe(1'b0, 1'b1);
      checks++;
      if (ifb.row !== 3'd5 || ifb.ck !== 4'b0010) begin
         errors++;
         $display("FAIL wrap_row5: got row=%0d ck=%b, expected row=5 ck=0010", ifb.row, ifb.ck);
      end
      strobe(1'b0, 1'b0);
      checks++;
      if (ifb.scanning !== 1'b0) begin
         errors++;
         $display("FAIL wrap_end: got scan=%b, expected 0", ifb.scanning);
      end
   endtask

   task automatic test_restart();
      strobe(1'b1, 1'b0);
      strobe(1'b0, 1'b1);
      strobe(1'b0, 1'b0);
      strobe(1'b1, 1'b1);
      checks++;
      if (ifa.row !== 2'd0 || ifa.ck !== 4'b0001 || ifa.scanning !== 1'b1) begin
         errors++;
         $display("FAIL restart_mid: got row=%0d ck=%b scan=%b, expected row=0 ck=0001 scan=1", ifa.row, ifa.ck, ifa.scanning);
      end
      for (int i = 0; i < 3; i++) strobe(1'b0, 1'($urandom_range(0, 1)));
      strobe(1'b1, 1'b0);
      checks++;
      if (ifa.row !== 2'd0 || ifa.scanning !== 1'b1) begin
         errors++;
         $display("FAIL restart_last: got row=%0d scan=%b, expected row=0 scan=1", ifa.row, ifa.scanning);
      end
   endtask

   task automatic test_back_to_back();
      logic [3*EW-1:0] e;
      logic f;
      f = 1'($urandom_range(0, 1));
      @(negedge clk); s_pin = 1'b0; fr_pin = f;
      model_apply(1'b0, f);
      exp_q.push_back({model_vec(2), model_vec(1), model_vec(0)});
      model_apply(1'b0, f);
      exp_q.push_back({model_vec(2), model_vec(1), model_vec(0)});
      for (int p = 0; p < 2; p++) begin
         @(negedge clk); cpl = 1'b1;
         repeat (3) @(posedge clk);
         #1;
         e = exp_q.pop_front();
         for (int d = 0; d < 3; d++) begin
            checks++;
            if (obs[d] !== e[d*EW +: EW]) begin
               errors++;
               $display("FAIL b2b_pulse%0d dut%0d: got %b, expected %b", p, d, obs[d], e[d*EW +: EW]);
            end
         end
         @(negedge clk); cpl = 1'b0;
         repeat (2) @(negedge clk);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (ifa.row !== 2'd2) begin
         errors++;
         $display("FAIL b2b_rows: got row=%0d, expected 2", ifa.row);
      end
   endtask

   task automatic test_glitch();
      @(negedge clk); cpl = 1'b1;
      @(negedge clk); cpl = 1'b0;
      repeat (8) @(negedge clk);
      checks++;
      if (!((ifa.row === 2'd2 || ifa.row === 2'd3) && ifa.scanning === 1'b1)) begin
         errors++;
         $display("FAIL glitch: got row=%0d scan=%b, expected row 2 or 3 with scan=1", ifa.row, ifa.scanning);
      end
   endtask

   task automatic test_mid_reset();
      reset_dut();
      strobe(1'b1, 1'b1);
      for (int i = 0; i < 3; i++) strobe(1'b0, 1'($urandom_range(0, 1)));
      checks++;
      if (ifa.row !== 2'd3) begin
         errors++;
         $display("FAIL pre_reset_row: got row=%0d, expected 3", ifa.row);
      end
      @(posedge clk);
      #2;
      n_rst = 1'b0;
      #1;
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (obs[d] !== RST_VEC) begin
            errors++;
            $display("FAIL async_reset dut%0d: got %b, expected %b", d, obs[d], RST_VEC);
         end
      end
      model_reset();
      cpl = 1'b1; s_pin = 1'b1;
      @(negedge clk); n_rst = 1'b1;
      repeat (8) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (obs[d] !== RST_VEC) begin
            errors++;
            $display("FAIL cpl_high_release dut%0d: got %b, expected %b", d, obs[d], RST_VEC);
         end
      end
      cpl = 1'b0;
      repeat (3) @(negedge clk);
      strobe(1'b1, 1'b0);
      checks++;
      if (ifa.scanning !== 1'b1 || ifa.row !== 2'd0) begin
         errors++;
         $display("FAIL rearm: got scan=%b row=%0d, expected scan=1 row=0", ifa.scanning, ifa.row);
      end
   endtask

   initial begin
      test_reset();
      test_polarity();
      test_basic_frame();
      test_phase_wrap();
      test_restart();
      test_back_to_back();
      test_glitch();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
